pipe_smult_acc: RTL

PIPE_SMULT_ACC -- requirements
Module: pipe_smult_acc

---
 rtl/pipe_smult_acc.sv | 105 ++++++++++
 1 files changed

// File: rtl/pipe_smult_acc.sv
// Pipelined signed/unsigned N x N multiplier with a saturating accumulator.
// Stall-all pipeline: when the output is not consumed, every stage holds.
module pipe_smult_acc #(
    parameter int N      = 8,
    parameter int STAGES = 2,
    parameter int ACC_W  = 2*N + 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             sgn,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             sat
);

    typedef struct packed {
        logic             valid;
        logic             acc_en;
        logic             acc_clr;
        logic [ACC_W-1:0] prod;
    } beat_t;

    logic             stall;
    beat_t            head;
    beat_t            tail;
    logic [ACC_W-1:0] acc;
    logic [2*N-1:0]   a_x;
    logic [2*N-1:0]   b_x;
    logic [2*N-1:0]   prod;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Operands are extended to 2N bits, so the truncated product is exact.
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        a_x          = sgn ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
        b_x          = sgn ? {{N{b[N-1]}}, b} : {{N{1'b0}}, b};
        prod         = a_x * b_x;
        head.valid   = in_valid && in_ready;
        head.acc_en  = acc_en;
        head.acc_clr = acc_clr;
        head.prod    = sgn ? ACC_W'($signed(prod)) : ACC_W'(prod);
    end

    generate
        if (STAGES == 1) begin : g_no_pipe
            assign tail = head;
        end else begin : g_pipe
            beat_t pipe [STAGES-1];

            // NOTE: the data fields are reset along with the valid bits so no X ever reaches the output mux.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < STAGES-1; i++) pipe[i] <= '0;
                end else if (!stall) begin
                    // NOTE: non-blocking assignments make every stage sample the pre-edge value of its predecessor.
                    pipe[0] <= head;
                    for (int i = 1; i < STAGES-1; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign tail = pipe[STAGES-2];
        end
    endgenerate

    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum;
    logic             ovf;
    logic [ACC_W-1:0] clamped;

    // One guard bit: overflow shows up as disagreement between the two top bits.
    always_comb begin
        base    = tail.acc_clr ? '0 : acc;
        sum     = tail.acc_en ? {base[ACC_W-1], base} + {tail.prod[ACC_W-1], tail.prod}
                              : {tail.prod[ACC_W-1], tail.prod};
        ovf     = sum[ACC_W] ^ sum[ACC_W-1];
        clamped = sum[ACC_W-1:0];
        if (ovf) clamped = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            sat       <= 1'b0;
            acc       <= '0;
        end else if (!stall) begin
            out_valid <= tail.valid;
            if (tail.valid) begin
                result <= clamped;
                sat    <= ovf;
                if (tail.acc_en) acc <= clamped;
            end
        end
    end

endmodule
